spad_port_arbiter: RTL and testbench
====================================

// Module: spad_port_arbiter
// PURPOSE
//  Shares one scratchpad (1R+1W, 1-cycle registered read) between NUM_REQ requesters (PEs / loaders).
//  Independent round-robin arbiters are used for the read port and the write port.
//  Each port uses a valid/ready handshake. Read data is returned to the granted requester, tagged.
//  A RAW hazard guard makes a same-cycle read of a just-written address return the new data.
// PARAMETERS
//  NUM_REQ           4   number of requesters (>=2)
//  DATA_BITWIDTH     16  scratchpad word width
//  ADDRESS_BITWIDTH  9   scratchpad address width (2^9 words)
// PORTS
//  clk                 in   1                      clock, rising edge
//  reset               in   1                      synchronous, active-high
//  rd_valid            in   NUM_REQ                per-requester read request
//  rd_addr             in   NUM_REQ*ADDRESS_BITWIDTH  packed read addresses, req i at [i*AW +: AW]
//  rd_ready            out  NUM_REQ                one-hot read grant (handshake completes when valid&ready)
//  rsp_valid           out  NUM_REQ                one-hot read-data valid, 1 cycle after grant
//  rsp_data            out  DATA_BITWIDTH          read data for requester flagged in rsp_valid
//  wr_valid            in   NUM_REQ                per-requester write request
//  wr_addr             in   NUM_REQ*ADDRESS_BITWIDTH  packed write addresses
//  wr_data             in   NUM_REQ*DATA_BITWIDTH  packed write data
//  wr_ready            out  NUM_REQ                one-hot write grant
//  spad_read_request   out  1                      to scratchpad read_request
//  spad_read_address   out  ADDRESS_BITWIDTH       to scratchpad read_address
//  spad_read_data      in   DATA_BITWIDTH          from scratchpad read_data
//  spad_write_enable   out  1                      to scratchpad write_enable
//  spad_write_address  out  ADDRESS_BITWIDTH       to scratchpad write_address
//  spad_write_data     out  DATA_BITWIDTH          to scratchpad write_data
// BEHAVIOUR
//  Reset: all outputs 0; both RR pointers select requester 0 as highest priority; in-flight response discarded.
//  Arbitration, per port, combinational in the cycle:
//   - Highest priority goes to the index after the last granted one, wrapping NUM_REQ-1 -> 0.
//   - The pointer updates only on a cycle with a grant; no grant means no pointer change.
//   - At most one ready bit per port. ready is never asserted without the matching valid.
//  Write port:
//   - spad_write_enable = |wr_ready.
//   - spad_write_address / spad_write_data = the granted requester's fields (0 when no grant).
//   - The write lands in memory at the end of the grant cycle.
//  Read port:
//   - spad_read_request = |rd_ready; spad_read_address = the granted address (0 when no grant).
//   - RAW guard: a read candidate whose address equals the address being written this cycle is masked.
//   - The masked candidate gets no rd_ready; the next candidate in RR order is granted instead.
//   - The masked requester retries next cycle and then sees the written data.
//  Response:
//   - The grant index and a pending flag are registered.
//   - In the cycle after a grant, rsp_valid[idx]=1 and rsp_data=spad_read_data.
//   - rsp_data is forced to 0 whenever no rsp_valid bit is set.
//   - The scratchpad's idle-bus constant (10101) therefore never reaches requesters.
//  Throughput: one read and one write per cycle; back-to-back grants to the same requester are allowed.
//   - Same requester is re-granted only if no other requester is valid.
//  Reset mid-operation:
//   - A grant and reset asserted in the same cycle produce no rsp_valid in the next cycle.
//   - The write is blocked by reset.
//  Requesters hold valid/addr/data stable until ready. Behaviour when a requester drops valid without ready is don't-care.
// TESTING
//  1. reset 2 cycles, all valid=0
//     -> all outputs 0, rsp_data=0 (bus reads 10101 internally, not forwarded).
//  2. Req0 writes 0x1234 @5, next cycle req2 reads @5
//     -> wr_ready[0] cycle0; rd_ready[2] cycle1; rsp_valid=4'b0100, rsp_data=0x1234 cycle2.
//  3. All 4 rd_valid held for 8 cycles
//     -> grants 0,1,2,3,0,1,2,3; one rsp per cycle, each lagging its grant by 1.
//  4. Same cycle: req1 writes 0xBEEF @9, req0 reads @9, req3 reads @7
//     -> req3 granted, req0 masked.
//     -> Next cycle req0 granted; its response = 0xBEEF.
//  5. Req1 granted read, reset asserted same cycle
//     -> next cycle rsp_valid=0, rsp_data=0; RR pointers back to req0.
//  6. Only req2 valid for 3 cycles (reads @0,1,2, preloaded 10,11,12)
//     -> rd_ready[2] every cycle; rsp_data 10,11,12 in consecutive cycles.

Source files
------------

// File: rtl/spad_port_arbiter.sv
// rtl/spad_port_arbiter.sv - round-robin 1R+1W scratchpad port arbiter
//
// Shares a single 1R+1W scratchpad (1-cycle registered read) among NUM_REQ
// requesters. The read and write ports each have their own round-robin
// arbiter. A read whose address matches the write granted in the same cycle
// is held off so that it retries and observes the new data.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-high reset
//   rd_valid/rd_addr    per-requester read requests, packed addresses
//   rd_ready            one-hot read grant
//   rsp_valid/rsp_data  one-hot response flag and data, one cycle after grant
//   wr_valid/wr_addr/wr_data  per-requester write requests, packed fields
//   wr_ready            one-hot write grant
//   spad_read_*         scratchpad read port (request/address out, data in)
//   spad_write_*        scratchpad write port
module spad_port_arbiter #(
   parameter int NUM_REQ          = 4,
   parameter int DATA_BITWIDTH    = 16,
   parameter int ADDRESS_BITWIDTH = 9
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   rd_valid,
   input  logic [NUM_REQ*ADDRESS_BITWIDTH-1:0]  rd_addr,
   output logic [NUM_REQ-1:0]                   rd_ready,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [DATA_BITWIDTH-1:0]             rsp_data,
   input  logic [NUM_REQ-1:0]                   wr_valid,
   input  logic [NUM_REQ*ADDRESS_BITWIDTH-1:0]  wr_addr,
   input  logic [NUM_REQ*DATA_BITWIDTH-1:0]     wr_data,
   output logic [NUM_REQ-1:0]                   wr_ready,
   output logic                                 spad_read_request,
   output logic [ADDRESS_BITWIDTH-1:0]          spad_read_address,
   input  logic [DATA_BITWIDTH-1:0]             spad_read_data,
   output logic                                 spad_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0]          spad_write_address,
   output logic [DATA_BITWIDTH-1:0]             spad_write_data
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef logic [IW-1:0] idx_t;

   // Pointers hold the index of the last granted requester; priority starts
   // at the one after it.
   idx_t rd_last_q, rd_last_d;
   idx_t wr_last_q, wr_last_d;
   idx_t rsp_idx_q, rsp_idx_d;
   logic rsp_pending_q, rsp_pending_d;

   logic [ADDRESS_BITWIDTH-1:0] rd_addr_arr [NUM_REQ];
   logic [ADDRESS_BITWIDTH-1:0] wr_addr_arr [NUM_REQ];
   logic [DATA_BITWIDTH-1:0]    wr_data_arr [NUM_REQ];

   logic [IW:0]        wr_pick, rd_pick;
   logic               wr_gnt_any, rd_gnt_any;
   idx_t               wr_gnt_idx, rd_gnt_idx;
   logic [NUM_REQ-1:0] rd_cand;

   // Returns {found, index} of the first set bit of req scanning upward from
   // last+1 with wraparound. Scanning from lowest to highest priority lets
   // the highest-priority hit overwrite earlier ones.
   function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input idx_t last);
      logic [IW:0] res;
      idx_t        pos;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         pos = IW'((int'(last) + k) % NUM_REQ);
         if (req[pos]) res = {1'b1, pos};
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_addr_arr[i] = rd_addr[i*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
         wr_addr_arr[i] = wr_addr[i*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
         wr_data_arr[i] = wr_data[i*DATA_BITWIDTH +: DATA_BITWIDTH];
      end
   end

   // Write port: reset suppresses the grant so nothing lands in memory.
   always_comb begin
      wr_pick            = rr_pick(wr_valid, wr_last_q);
      wr_gnt_any         = wr_pick[IW] & ~reset;
      wr_gnt_idx         = wr_pick[IW-1:0];
      wr_ready           = '0;
      spad_write_enable  = wr_gnt_any;
      spad_write_address = '0;
      spad_write_data    = '0;
      if (wr_gnt_any) begin
         wr_ready[wr_gnt_idx] = 1'b1;
         spad_write_address   = wr_addr_arr[wr_gnt_idx];
         spad_write_data      = wr_data_arr[wr_gnt_idx];
      end
   end

   // Read port: a candidate reading the address being written this cycle is
   // dropped from arbitration, so the grant passes to the next one in order
   // and the masked requester sees the new data on its retry.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_cand[i] = rd_valid[i] &
                      ~(wr_gnt_any && (rd_addr_arr[i] == spad_write_address));
      end
      rd_pick           = rr_pick(rd_cand, rd_last_q);
      rd_gnt_any        = rd_pick[IW];
      rd_gnt_idx        = rd_pick[IW-1:0];
      rd_ready          = '0;
      spad_read_request = rd_gnt_any;
      spad_read_address = '0;
      if (rd_gnt_any) begin
         rd_ready[rd_gnt_idx] = 1'b1;
         spad_read_address    = rd_addr_arr[rd_gnt_idx];
      end
   end

   always_comb begin
      wr_last_d     = wr_gnt_any ? wr_gnt_idx : wr_last_q;
      rd_last_d     = rd_gnt_any ? rd_gnt_idx : rd_last_q;
      rsp_pending_d = rd_gnt_any;
      rsp_idx_d     = rd_gnt_any ? rd_gnt_idx : rsp_idx_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_last_q     <= IW'(NUM_REQ - 1);
         rd_last_q     <= IW'(NUM_REQ - 1);
         rsp_idx_q     <= '0;
         rsp_pending_q <= 1'b0;
      end else begin
         wr_last_q     <= wr_last_d;
         rd_last_q     <= rd_last_d;
         rsp_idx_q     <= rsp_idx_d;
         rsp_pending_q <= rsp_pending_d;
      end
   end

   // The read bus carries an idle constant when no read is pending; gating
   // keeps it from reaching requesters.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (rsp_pending_q) begin
         rsp_valid[rsp_idx_q] = 1'b1;
         rsp_data             = spad_read_data;
      end
   end

endmodule

// File: tb/tb_spad_port_arbiter.sv
// tb/tb_spad_port_arbiter.sv - self-checking bench for spad_port_arbiter
module tb_spad_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 9;

   logic            clk;
   logic            reset;
   logic [N-1:0]    rd_valid;
   logic [N*AW-1:0] rd_addr;
   logic [N-1:0]    rd_ready;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [N-1:0]    wr_valid;
   logic [N*AW-1:0] wr_addr;
   logic [N*DW-1:0] wr_data;
   logic [N-1:0]    wr_ready;
   logic            spad_read_request;
   logic [AW-1:0]   spad_read_address;
   logic [DW-1:0]   spad_read_data;
   logic            spad_write_enable;
   logic [AW-1:0]   spad_write_address;
   logic [DW-1:0]   spad_write_data;

   int checks = 0;
   int errors = 0;

   spad_port_arbiter #(.NUM_REQ(N), .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .spad_read_request(spad_read_request), .spad_read_address(spad_read_address),
      .spad_read_data(spad_read_data),
      .spad_write_enable(spad_write_enable), .spad_write_address(spad_write_address),
      .spad_write_data(spad_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scratchpad: registered read, idle bus shows 5'b10101.
   logic [DW-1:0] spad_mem [1 << AW];
   always @(posedge clk) begin
      if (spad_write_enable) spad_mem[spad_write_address] <= spad_write_data;
      spad_read_data <= spad_read_request ? spad_mem[spad_read_address] : 16'h0015;
   end

   task automatic set_rd(input int i, input int a);
      rd_addr[i*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int i, input int a, input int d);
      wr_addr[i*AW +: AW] = AW'(a);
      wr_data[i*DW +: DW] = DW'(d);
   endtask

   task automatic do_reset();
      reset = 1'b1; rd_valid = '0; wr_valid = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference round-robin: first requested index after 'last', wrapping.
   function automatic int rr_pick(input logic [N-1:0] c, input int last);
      for (int k = 1; k <= N; k++) begin
         if (c[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic test_reset();
      reset = 1'b1; rd_valid = '0; wr_valid = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) reset = 1'b0;
         #2;
         checks++;
         if ({rd_ready, wr_ready, rsp_valid, spad_read_request, spad_write_enable} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl c%0d: got rd=%b wr=%b rsp=%b rreq=%b we=%b, want all 0",
                     c, rd_ready, wr_ready, rsp_valid, spad_read_request, spad_write_enable);
         end
         checks++;
         if ({rsp_data, spad_read_address, spad_write_address, spad_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_data c%0d: got rsp_data=%h ra=%h wa=%h wd=%h, want 0",
                     c, rsp_data, spad_read_address, spad_write_address, spad_write_data);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_write_read();
      do_reset();
      wr_valid = 4'b0001; set_wr(0, 5, 16'h1234);
      #2;
      checks++;
      if ({wr_ready, spad_write_enable, spad_write_address, spad_write_data} !==
          {4'b0001, 1'b1, 9'd5, 16'h1234}) begin
         errors++;
         $display("FAIL wr_grant: got rdy=%b we=%b wa=%h wd=%h, want 0001 1 005 1234",
                  wr_ready, spad_write_enable, spad_write_address, spad_write_data);
      end
      @(negedge clk);
      wr_valid = '0; rd_valid = 4'b0100; set_rd(2, 5);
      #2;
      checks++;
      if ({rd_ready, spad_read_request, spad_read_address, rsp_valid} !==
          {4'b0100, 1'b1, 9'd5, 4'b0000}) begin
         errors++;
         $display("FAIL rd_grant: got rdy=%b rreq=%b ra=%h rsp=%b, want 0100 1 005 0000",
                  rd_ready, spad_read_request, spad_read_address, rsp_valid);
      end
      @(negedge clk);
      rd_valid = '0;
      #2;
      checks++;
      if ({rsp_valid, rsp_data} !== {4'b0100, 16'h1234}) begin
         errors++;
         $display("FAIL rd_rsp: got rsp=%b data=%h, want 0100 1234", rsp_valid, rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic test_rr_reads();
      logic [N-1:0] er, ev;
      do_reset();
      for (int i = 0; i < N; i++) set_rd(i, 100 + i);
      for (int c = 0; c < 9; c++) begin
         rd_valid = (c < 8) ? 4'b1111 : 4'b0000;
         er = (c < 8) ? N'(1) << (c % N) : '0;
         ev = (c > 0) ? N'(1) << ((c - 1) % N) : '0;
         #2;
         checks++;
         if (rd_ready !== er || rsp_valid !== ev) begin
            errors++;
            $display("FAIL rr_seq c%0d: got rdy=%b rsp=%b, want rdy=%b rsp=%b",
                     c, rd_ready, rsp_valid, er, ev);
         end
         @(negedge clk);
      end
      rd_valid = '0;
   endtask

   task automatic test_raw_guard();
      do_reset();
      wr_valid = 4'b0010; set_wr(1, 9, 16'hBEEF);
      rd_valid = 4'b1001; set_rd(0, 9); set_rd(3, 7);
      #2;
      checks++;
      if ({wr_ready, rd_ready, spad_read_address} !== {4'b0010, 4'b1000, 9'd7}) begin
         errors++;
         $display("FAIL raw_mask: got wr=%b rd=%b ra=%h, want 0010 1000 007",
                  wr_ready, rd_ready, spad_read_address);
      end
      @(negedge clk);
      wr_valid = '0; rd_valid = 4'b0001;
      #2;
      checks++;
      if ({rd_ready, rsp_valid} !== {4'b0001, 4'b1000}) begin
         errors++;
         $display("FAIL raw_retry: got rd=%b rsp=%b, want 0001 1000", rd_ready, rsp_valid);
      end
      @(negedge clk);
      rd_valid = '0;
      #2;
      checks++;
      if ({rsp_valid, rsp_data} !== {4'b0001, 16'hBEEF}) begin
         errors++;
         $display("FAIL raw_data: got rsp=%b data=%h, want 0001 beef", rsp_valid, rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      rd_valid = 4'b0010; set_rd(1, 3);
      #2;
      checks++;
      if (rd_ready !== 4'b0010) begin
         errors++;
         $display("FAIL mid_pre: got rd=%b, want 0010", rd_ready);
      end
      @(negedge clk);
      reset = 1'b1; wr_valid = 4'b0001; set_wr(0, 3, 16'h5555);
      #2;
      checks++;
      if ({rd_ready, rsp_valid, wr_ready, spad_write_enable} !== {4'b0010, 4'b0010, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL mid_rst: got rd=%b rsp=%b wr=%b we=%b, want 0010 0010 0000 0",
                  rd_ready, rsp_valid, wr_ready, spad_write_enable);
      end
      @(negedge clk);
      reset = 1'b0; wr_valid = '0; rd_valid = 4'b1111;
      #2;
      checks++;
      if ({rsp_valid, rsp_data, rd_ready} !== {4'b0000, 16'h0000, 4'b0001}) begin
         errors++;
         $display("FAIL mid_post: got rsp=%b data=%h rd=%b, want 0000 0000 0001",
                  rsp_valid, rsp_data, rd_ready);
      end
      @(negedge clk);
      rd_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_single_req();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         wr_valid = 4'b0001; set_wr(0, c, 10 + c);
         #2;
         checks++;
         if (wr_ready !== 4'b0001) begin
            errors++;
            $display("FAIL preload c%0d: got wr=%b, want 0001", c, wr_ready);
         end
         @(negedge clk);
      end
      wr_valid = '0;
      for (int c = 0; c < 4; c++) begin
         rd_valid = (c < 3) ? 4'b0100 : 4'b0000;
         set_rd(2, c);
         #2;
         checks++;
         if (rd_ready !== ((c < 3) ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL single_rdy c%0d: got %b", c, rd_ready);
         end
         if (c > 0) begin
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_data !== DW'(10 + c - 1)) begin
               errors++;
               $display("FAIL single_rsp c%0d: got rsp=%b data=%0d, want 0100 %0d",
                        c, rsp_valid, rsp_data, 10 + c - 1);
            end
         end
         @(negedge clk);
      end
      rd_valid = '0;
   endtask

   task automatic test_random();
      int            rd_last_m, wr_last_m, eg_w, eg_r, pidx_m;
      logic          pend_m, pknown_m;
      logic [DW-1:0] pdata_m;
      logic [DW-1:0] mem_m [16];
      logic          known_m [16];
      logic [N-1:0]  cand, exp_rv;
      logic [AW-1:0] wa, ra;
      do_reset();
      rd_last_m = N - 1; wr_last_m = N - 1; pend_m = 1'b0; pidx_m = 0;
      pknown_m = 1'b0; pdata_m = '0;
      for (int i = 0; i < 16; i++) begin known_m[i] = 1'b0; mem_m[i] = '0; end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rd_valid[i] && $urandom_range(0, 2) != 0) begin
               rd_valid[i] = 1'b1; set_rd(i, $urandom_range(0, 15));
            end
            if (!wr_valid[i] && $urandom_range(0, 2) == 0) begin
               wr_valid[i] = 1'b1; set_wr(i, $urandom_range(0, 15), $urandom_range(0, 65535));
            end
         end
         reset = ($urandom_range(0, 39) == 0);
         #2;
         eg_w = reset ? -1 : rr_pick(wr_valid, wr_last_m);
         wa   = (eg_w >= 0) ? wr_addr[eg_w*AW +: AW] : '0;
         for (int i = 0; i < N; i++)
            cand[i] = rd_valid[i] && !(eg_w >= 0 && rd_addr[i*AW +: AW] == wa);
         eg_r = rr_pick(cand, rd_last_m);
         ra   = (eg_r >= 0) ? rd_addr[eg_r*AW +: AW] : '0;
         exp_rv = pend_m ? N'(1) << pidx_m : '0;
         checks++;
         if (wr_ready !== ((eg_w >= 0) ? N'(1) << eg_w : N'(0)) || spad_write_enable !== (eg_w >= 0) ||
             spad_write_address !== wa ||
             spad_write_data !== ((eg_w >= 0) ? wr_data[eg_w*DW +: DW] : DW'(0))) begin
            errors++;
            $display("FAIL rnd_wr c%0d: got rdy=%b we=%b wa=%h wd=%h, want grant %0d wa=%h",
                     c, wr_ready, spad_write_enable, spad_write_address, spad_write_data, eg_w, wa);
         end
         checks++;
         if (rd_ready !== ((eg_r >= 0) ? N'(1) << eg_r : N'(0)) || spad_read_request !== (eg_r >= 0) ||
             spad_read_address !== ra) begin
            errors++;
            $display("FAIL rnd_rd c%0d: got rdy=%b rreq=%b ra=%h, want grant %0d ra=%h",
                     c, rd_ready, spad_read_request, spad_read_address, eg_r, ra);
         end
         checks++;
         if (rsp_valid !== exp_rv || (!pend_m && rsp_data !== '0) ||
             (pend_m && pknown_m && rsp_data !== pdata_m)) begin
            errors++;
            $display("FAIL rnd_rsp c%0d: got rsp=%b data=%h, want rsp=%b data=%h (known=%0b)",
                     c, rsp_valid, rsp_data, exp_rv, pend_m ? pdata_m : DW'(0), pknown_m);
         end
         if (reset) begin
            rd_last_m = N - 1; wr_last_m = N - 1; pend_m = 1'b0;
         end else begin
            pend_m = (eg_r >= 0);
            if (eg_r >= 0) begin
               rd_last_m = eg_r; pidx_m = eg_r;
               pdata_m = mem_m[ra[3:0]]; pknown_m = known_m[ra[3:0]];
            end
            if (eg_w >= 0) begin
               wr_last_m = eg_w;
               mem_m[wa[3:0]] = wr_data[eg_w*DW +: DW]; known_m[wa[3:0]] = 1'b1;
            end
         end
         @(negedge clk);
         if (eg_r >= 0) rd_valid[eg_r] = 1'b0;
         if (eg_w >= 0) wr_valid[eg_w] = 1'b0;
      end
      reset = 1'b0; rd_valid = '0; wr_valid = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_rr_reads();
      test_raw_guard();
      test_reset_mid();
      test_single_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
